// File: rtl/cpu_pkg.sv
// Shared widths and encodings for the decode/execute boundary.
// Operand-forwarding selects and the ALU op codes live here so every stage agrees.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    XOR = 3'b010,
    BEQ = 3'b011,
    OR  = 3'b100
  } alu_op_t;

  typedef enum logic [1:0] {
    RF  = 2'd0,
    MEM = 2'd1,
    WB  = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding mux for one source operand: picks the youngest in-flight producer
// of the register, falling back to register-file data. Register 0 never forwards.
module fwd_unit #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output cpu_pkg::fwd_sel_t sel,
  output logic [DATA_W-1:0] operand
);
  import cpu_pkg::*;

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == src);
  assign wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == src);

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    sel     = RF;
    operand = rf_data;
    if (mem_hit) begin
      sel     = MEM;
      operand = mem_result;
    end else if (wb_hit) begin
      sel     = WB;
      operand = wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand selection and forwarding, load-use stall,
// branch flush and a saturating stall counter for performance debug.
module id_ex_stage #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [15:0]       id_imm,
  input  logic              id_use_imm,
  input  logic              id_uses_rt,
  input  logic [CTRL_W-1:0] id_alu_op,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              ex_stall,
  input  logic              flush,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              stall_id,
  output logic [CNT_W-1:0]  stall_cnt
);
  import cpu_pkg::*;

  fwd_sel_t          rs_sel;
  fwd_sel_t          rt_sel;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic [DATA_W-1:0] op_b;
  logic              load_use;
  logic              unused_sel;

  fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src(id_rs), .rf_data(id_rs_data),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .sel(rs_sel), .operand(fwd_rs)
  );

  fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src(id_rt), .rf_data(id_rt_data),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .sel(rt_sel), .operand(fwd_rt)
  );

  // Selects are kept for debug visibility; the datapath only needs the operands.
  assign unused_sel = ^{rs_sel, rt_sel};

  assign op_b = id_use_imm ? {{(DATA_W-16){id_imm[15]}}, id_imm} : fwd_rt;

  // A load in EX cannot forward yet; a consumer in ID must wait one cycle.
  assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  // A flush drops the decode slot, so decode must not be told to hold it.
  assign stall_id = !flush && (ex_stall || load_use);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; kills and bubbles clear operands too, so EX never sees stale data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_ctrl      <= CTRL_W'(ADD);
      ex_valid      <= 1'b0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_store_data <= '0;
    end else if (flush || (!ex_stall && load_use)) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_ctrl      <= CTRL_W'(ADD);
      ex_valid      <= 1'b0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_store_data <= '0;
    end else if (!ex_stall) begin
      alu_a         <= fwd_rs;
      alu_b         <= op_b;
      alu_ctrl      <= id_alu_op;
      ex_valid      <= id_valid;
      ex_rd         <= id_rd;
      ex_reg_write  <= id_valid && id_reg_write;
      ex_mem_read   <= id_valid && id_mem_read;
      ex_mem_write  <= id_valid && id_mem_write;
      ex_store_data <= fwd_rt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall_id && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding, immediates, load-use bubble,
// flush priority, counter saturation and asynchronous reset.
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic [31:0]       id_rs_data, id_rt_data;
  logic [15:0]       id_imm;
  logic              id_use_imm, id_uses_rt;
  logic [2:0]        id_alu_op;
  logic              id_mem_read, id_mem_write, id_reg_write;
  logic              mem_reg_write;
  logic [4:0]        mem_rd;
  logic [31:0]       mem_result;
  logic              wb_reg_write;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_result;
  logic              ex_stall, flush;
  logic [31:0]       alu_a, alu_b;
  logic [2:0]        alu_ctrl;
  logic              ex_valid;
  logic [4:0]        ex_rd;
  logic              ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0]       ex_store_data;
  logic              stall_id;
  logic [CNT_W-1:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_uses_rt(id_uses_rt),
    .id_alu_op(id_alu_op), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_stall(ex_stall), .flush(flush),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
    .stall_id(stall_id), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_use_imm = 0; id_uses_rt = 0; id_alu_op = 3'(ADD);
    id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
  endtask

  initial begin
    reset = 0;
    clear_id();
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    ex_stall = 0; flush = 0;

    #3;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    reset = 1;

    // Plain ADD from register-file data.
    id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 5; id_uses_rt = 1;
    id_rs_data = 5; id_rt_data = 7; id_alu_op = 3'(ADD); id_reg_write = 1;
    step();
    check("add_a", alu_a, 32'd5);
    check("add_b", alu_b, 32'd7);
    check("add_ctrl", 32'(alu_ctrl), 32'd0);
    check("add_valid", 32'(ex_valid), 32'd1);
    check("add_rd", 32'(ex_rd), 32'd5);
    check("add_regw", 32'(ex_reg_write), 32'd1);

    // MEM beats WB when both match.
    id_rs = 3; id_alu_op = 3'(SUB);
    mem_reg_write = 1; mem_rd = 3; mem_result = 32'h11;
    wb_reg_write = 1; wb_rd = 3; wb_result = 32'h22;
    step();
    check("fwd_mem_a", alu_a, 32'h11);
    check("fwd_mem_b", alu_b, 32'd7);
    check("fwd_ctrl", 32'(alu_ctrl), 32'd1);

    // Only WB matches.
    mem_rd = 9;
    step();
    check("fwd_wb_a", alu_a, 32'h22);

    // Register 0 never forwards.
    id_rs = 0; id_rs_data = 32'h33; mem_rd = 0; wb_rd = 0;
    step();
    check("fwd_r0_a", alu_a, 32'h33);

    // Sign-extended immediates; store data still carries rt.
    mem_reg_write = 0; wb_reg_write = 0;
    id_use_imm = 1; id_imm = 16'hFFFE; id_mem_write = 1;
    step();
    check("imm_neg_b", alu_b, 32'hFFFF_FFFE);
    check("imm_store", ex_store_data, 32'd7);
    check("imm_memw", 32'(ex_mem_write), 32'd1);
    id_imm = 16'h7FFF; id_mem_write = 0;
    step();
    check("imm_pos_b", alu_b, 32'h0000_7FFF);

    // Load r4, then a consumer of r4.
    id_rs = 1; id_rs_data = 32'h100; id_rd = 4; id_imm = 16'd4;
    id_mem_read = 1; id_reg_write = 1; id_uses_rt = 0;
    step();
    check("ld_memr", 32'(ex_mem_read), 32'd1);
    check("ld_b", alu_b, 32'd4);
    id_rs = 4; id_rs_data = 32'hDEAD; id_rt = 2; id_rd = 6; id_uses_rt = 1;
    id_use_imm = 0; id_mem_read = 0; id_alu_op = 3'(XOR);
    #1;
    check("lu_stall", 32'(stall_id), 32'd1);
    step();
    check("lu_bubble_v", 32'(ex_valid), 32'd0);
    check("lu_bubble_mr", 32'(ex_mem_read), 32'd0);
    check("lu_bubble_a", alu_a, 32'd0);
    check("lu_cnt", 32'(stall_cnt), 32'd1);
    check("lu_clear", 32'(stall_id), 32'd0);
    wb_reg_write = 1; wb_rd = 4; wb_result = 32'h1234;
    step();
    check("lu_fwd_a", alu_a, 32'h1234);
    check("lu_ctrl", 32'(alu_ctrl), 32'd2);
    check("lu_valid", 32'(ex_valid), 32'd1);

    // Downstream stall holds everything.
    ex_stall = 1; id_rs = 1; id_rs_data = 32'h999; wb_reg_write = 0;
    #1;
    check("hold_stall", 32'(stall_id), 32'd1);
    step();
    check("hold_a", alu_a, 32'h1234);
    check("hold_rd", 32'(ex_rd), 32'd6);
    check("hold_cnt", 32'(stall_cnt), 32'd2);
    ex_stall = 0;

    // Flush wins over ex_stall and a load-use hazard.
    id_rs = 1; id_rd = 4; id_mem_read = 1; id_uses_rt = 0; id_alu_op = 3'(ADD);
    step();
    id_rs = 4; id_mem_read = 0;
    ex_stall = 1; flush = 1;
    #1;
    check("fl_stall", 32'(stall_id), 32'd0);
    step();
    check("fl_valid", 32'(ex_valid), 32'd0);
    check("fl_memr", 32'(ex_mem_read), 32'd0);
    check("fl_regw", 32'(ex_reg_write), 32'd0);
    check("fl_cnt", 32'(stall_cnt), 32'd2);
    flush = 0;

    // Saturate the counter, then keep stalling.
    for (int i = 0; i < 13; i++) step();
    check("sat_full", 32'(stall_cnt), 32'hF);
    step();
    step();
    check("sat_hold", 32'(stall_cnt), 32'hF);
    ex_stall = 0;

    // Asynchronous reset mid-run with a valid instruction in EX.
    clear_id();
    id_valid = 1; id_rs_data = 32'h55; id_rd = 3; id_reg_write = 1;
    step();
    check("pre_rst_valid", 32'(ex_valid), 32'd1);
    #1 reset = 0;
    #1;
    check("arst_valid", 32'(ex_valid), 32'd0);
    check("arst_a", alu_a, 32'd0);
    check("arst_rd", 32'(ex_rd), 32'd0);
    check("arst_regw", 32'(ex_reg_write), 32'd0);
    check("arst_cnt", 32'(stall_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
